// File: rtl/store_buffer_if.sv
// Store-side request and memory-write handshake bundle for store_buffer.
// master drives stores and accepts memory writes; slave is the buffer itself.
interface store_buffer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                  st_valid;
    logic                  st_ready;
    logic [ADDR_W-1:0]     st_addr;
    logic [1:0]            st_size;
    logic [DATA_W-1:0]     st_data;
    logic                  st_err;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;

    modport master (
        output st_valid, st_addr, st_size, st_data, mem_ready,
        input  st_ready, st_err, mem_valid, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  st_valid, st_addr, st_size, st_data, mem_ready,
        output st_ready, st_err, mem_valid, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: lane-aligns stores, rejects illegal ones, queues them in a FIFO to memory.
// Define STORE_BUFFER_MERGE_EN to merge same-word stores into the newest queued entry.
module store_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    store_buffer_if.slave          bus,
    output logic                   sb_empty,
    output logic [$clog2(DEPTH):0] sb_count
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [BYTES-1:0]  be_q   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    logic [3:0]        nbytes;
    logic [OFF_W-1:0]  off;
    logic              illegal;
    logic [BYTES-1:0]  size_mask;
    logic [DATA_W-1:0] data_mask;
    logic [BYTES-1:0]  al_be;
    logic [DATA_W-1:0] al_data;
    logic [ADDR_W-1:0] word_addr;
    logic              full, empty, accept, push, pop, merge;

    always_comb begin
        nbytes    = 4'd1 << bus.st_size;
        off       = bus.st_addr[OFF_W-1:0];
        // Offset must be a multiple of the access size; oversize stores are always illegal.
        illegal   = (32'(nbytes) > BYTES) || ((off & OFF_W'(nbytes - 4'd1)) != '0);
        size_mask = '0;
        data_mask = '0;
        for (int i = 0; i < int'(BYTES); i++) begin
            size_mask[i]       = (i < int'(nbytes));
            data_mask[8*i +: 8] = {8{size_mask[i]}};
        end
        al_be     = size_mask << off;
        al_data   = (bus.st_data & data_mask) << {off, 3'b000};
        word_addr = {bus.st_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    end

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign accept = bus.st_valid && !full && !illegal;
    assign pop    = !empty && bus.mem_ready;
    assign err_d  = bus.st_valid && illegal;

`ifdef STORE_BUFFER_MERGE_EN
    logic [PTR_W-1:0] tail_idx;
    assign tail_idx = wr_ptr_q - PTR_W'(1);
    // With one entry, merging is only safe if that entry is not leaving this cycle.
    assign merge = accept && (word_addr == addr_q[tail_idx]) &&
                   ((count_q >= CNT_W'(2)) || ((count_q == CNT_W'(1)) && !pop));
`else
    assign merge = 1'b0;
`endif

    assign push    = accept && !merge;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            err_q   <= err_d;
            count_q <= count_d;
            if (push) begin
                addr_q[wr_ptr_q] <= word_addr;
                data_q[wr_ptr_q] <= al_data;
                be_q[wr_ptr_q]   <= al_be;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
`ifdef STORE_BUFFER_MERGE_EN
            if (merge) begin
                be_q[tail_idx] <= be_q[tail_idx] | al_be;
                for (int i = 0; i < int'(BYTES); i++) begin
                    if (al_be[i]) data_q[tail_idx][8*i +: 8] <= al_data[8*i +: 8];
                end
            end
`endif
        end
    end

    assign bus.st_ready  = !full;
    assign bus.st_err    = err_q;
    assign bus.mem_valid = !empty;
    assign bus.mem_addr  = addr_q[rd_ptr_q];
    assign bus.mem_wdata = data_q[rd_ptr_q];
    assign bus.mem_be    = be_q[rd_ptr_q];
    assign sb_empty      = empty;
    assign sb_count      = count_q;
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (32-bit instance plus a 64-bit instance).
module tb_store_buffer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sb_empty, sb64_empty;
    logic [2:0] sb_count, sb64_count;
    int         tests = 0;
    int         failed = 0;

    store_buffer_if #(.DATA_W(32), .ADDR_W(32)) sb_if ();
    store_buffer_if #(.DATA_W(64), .ADDR_W(32)) sb64_if ();

    store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (sb_if),
        .sb_empty (sb_empty),
        .sb_count (sb_count)
    );

    store_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
        .clk      (clk),
        .reset    (reset),
        .bus      (sb64_if),
        .sb_empty (sb64_empty),
        .sb_count (sb64_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        sb_if.st_valid = 1'b1;
        sb_if.st_addr  = addr;
        sb_if.st_size  = size;
        sb_if.st_data  = data;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (sb_if.st_ready !== 1'b1) begin failed++; $display("FAIL rst_st_ready: got %0h exp 1", sb_if.st_ready); end
        tests++; if (sb_if.st_err !== 1'b0) begin failed++; $display("FAIL rst_st_err: got %0h exp 0", sb_if.st_err); end
        tests++; if (sb_if.mem_valid !== 1'b0) begin failed++; $display("FAIL rst_mem_valid: got %0h exp 0", sb_if.mem_valid); end
        tests++; if (sb_if.mem_addr !== 32'h0) begin failed++; $display("FAIL rst_mem_addr: got %h exp 0", sb_if.mem_addr); end
        tests++; if (sb_if.mem_wdata !== 32'h0) begin failed++; $display("FAIL rst_mem_wdata: got %h exp 0", sb_if.mem_wdata); end
        tests++; if (sb_if.mem_be !== 4'h0) begin failed++; $display("FAIL rst_mem_be: got %b exp 0000", sb_if.mem_be); end
        tests++; if (sb_empty !== 1'b1) begin failed++; $display("FAIL rst_sb_empty: got %0h exp 1", sb_empty); end
        tests++; if (sb_count !== 3'd0) begin failed++; $display("FAIL rst_sb_count: got %0d exp 0", sb_count); end
    endtask

    task automatic test_byte_store();
        apply_reset();
        sb_if.mem_ready = 1'b0;
        store(32'h1003, 2'd0, 32'h0000_00AB);
        step();
        sb_if.st_valid = 1'b0;
        tests++; if (sb_if.mem_valid !== 1'b1) begin failed++; $display("FAIL byte_mem_valid: got %0h exp 1", sb_if.mem_valid); end
        tests++; if (sb_if.mem_addr !== 32'h1000) begin failed++; $display("FAIL byte_mem_addr: got %h exp 00001000", sb_if.mem_addr); end
        tests++; if (sb_if.mem_wdata !== 32'hAB00_0000) begin failed++; $display("FAIL byte_mem_wdata: got %h exp ab000000", sb_if.mem_wdata); end
        tests++; if (sb_if.mem_be !== 4'b1000) begin failed++; $display("FAIL byte_mem_be: got %b exp 1000", sb_if.mem_be); end
        tests++; if (sb_count !== 3'd1) begin failed++; $display("FAIL byte_sb_count: got %0d exp 1", sb_count); end
        // Half store to 0x2002: lanes 2-3, upper data bits must be masked off.
        apply_reset();
        store(32'h2002, 2'd1, 32'hFFFF_BEEF);
        step();
        sb_if.st_valid = 1'b0;
        tests++; if (sb_if.mem_wdata !== 32'hBEEF_0000) begin failed++; $display("FAIL half_mem_wdata: got %h exp beef0000", sb_if.mem_wdata); end
        tests++; if (sb_if.mem_be !== 4'b1100) begin failed++; $display("FAIL half_mem_be: got %b exp 1100", sb_if.mem_be); end
    endtask

    task automatic test_misaligned();
        apply_reset();
        sb_if.mem_ready = 1'b0;
        store(32'h2001, 2'd1, 32'h0000_1234);
        step();
        sb_if.st_valid = 1'b0;
        tests++; if (sb_if.st_err !== 1'b1) begin failed++; $display("FAIL mis_err_pulse: got %0h exp 1", sb_if.st_err); end
        tests++; if (sb_count !== 3'd0) begin failed++; $display("FAIL mis_count_a: got %0d exp 0", sb_count); end
        tests++; if (sb_if.mem_valid !== 1'b0) begin failed++; $display("FAIL mis_mem_valid_a: got %0h exp 0", sb_if.mem_valid); end
        step();
        tests++; if (sb_if.st_err !== 1'b0) begin failed++; $display("FAIL mis_err_clear: got %0h exp 0", sb_if.st_err); end
        tests++; if (sb_count !== 3'd0) begin failed++; $display("FAIL mis_count_b: got %0d exp 0", sb_count); end
        tests++; if (sb_if.mem_valid !== 1'b0) begin failed++; $display("FAIL mis_mem_valid_b: got %0h exp 0", sb_if.mem_valid); end
    endtask

    task automatic test_oversize();
        apply_reset();
        sb_if.mem_ready = 1'b0;
        store(32'h0000_0000, 2'd3, 32'hCAFE_F00D);
        step();
        sb_if.st_valid = 1'b0;
        tests++; if (sb_if.st_err !== 1'b1) begin failed++; $display("FAIL over_err_pulse: got %0h exp 1", sb_if.st_err); end
        tests++; if (sb_count !== 3'd0) begin failed++; $display("FAIL over_count: got %0d exp 0", sb_count); end
        step();
        tests++; if (sb_if.st_err !== 1'b0) begin failed++; $display("FAIL over_err_clear: got %0h exp 0", sb_if.st_err); end
        // 64-bit instance: doubleword to 0x08 is legal.
        sb64_if.mem_ready = 1'b0;
        sb64_if.st_valid  = 1'b1;
        sb64_if.st_addr   = 32'h08;
        sb64_if.st_size   = 2'd3;
        sb64_if.st_data   = 64'h1122_3344_5566_7788;
        step();
        sb64_if.st_valid = 1'b0;
        tests++; if (sb64_if.mem_be !== 8'hFF) begin failed++; $display("FAIL dw_mem_be: got %h exp ff", sb64_if.mem_be); end
        tests++; if (sb64_if.mem_addr !== 32'h08) begin failed++; $display("FAIL dw_mem_addr: got %h exp 00000008", sb64_if.mem_addr); end
        tests++; if (sb64_if.mem_wdata !== 64'h1122_3344_5566_7788) begin failed++; $display("FAIL dw_mem_wdata: got %h exp 1122334455667788", sb64_if.mem_wdata); end
        tests++; if (sb64_if.st_err !== 1'b0) begin failed++; $display("FAIL dw_err: got %0h exp 0", sb64_if.st_err); end
        // Drain it, then a word to 0x0C lands in the upper lanes.
        sb64_if.mem_ready = 1'b1;
        step();
        sb64_if.mem_ready = 1'b0;
        sb64_if.st_valid  = 1'b1;
        sb64_if.st_addr   = 32'h0C;
        sb64_if.st_size   = 2'd2;
        sb64_if.st_data   = 64'hFFFF_FFFF_DEAD_BEEF;
        step();
        sb64_if.st_valid = 1'b0;
        tests++; if (sb64_if.mem_be !== 8'hF0) begin failed++; $display("FAIL w64_mem_be: got %h exp f0", sb64_if.mem_be); end
        tests++; if (sb64_if.mem_wdata !== 64'hDEAD_BEEF_0000_0000) begin failed++; $display("FAIL w64_mem_wdata: got %h exp deadbeef00000000", sb64_if.mem_wdata); end
        tests++; if (sb64_if.mem_addr !== 32'h08) begin failed++; $display("FAIL w64_mem_addr: got %h exp 00000008", sb64_if.mem_addr); end
        tests++; if (sb64_count !== 3'd1) begin failed++; $display("FAIL w64_count: got %0d exp 1", sb64_count); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] exp_addr [4];
        exp_addr = '{32'h10, 32'h14, 32'h18, 32'h1C};
        apply_reset();
        sb_if.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(exp_addr[i], 2'd2, 32'hA000_0000 + 32'(i));
            step();
        end
        tests++; if (sb_count !== 3'd4) begin failed++; $display("FAIL fill_count: got %0d exp 4", sb_count); end
        tests++; if (sb_if.st_ready !== 1'b0) begin failed++; $display("FAIL fill_st_ready: got %0h exp 0", sb_if.st_ready); end
        store(32'h20, 2'd2, 32'hBBBB_BBBB);
        step();
        tests++; if (sb_count !== 3'd4) begin failed++; $display("FAIL fifth_held_count: got %0d exp 4", sb_count); end
        tests++; if (sb_if.mem_addr !== 32'h10) begin failed++; $display("FAIL head_stable: got %h exp 00000010", sb_if.mem_addr); end
        tests++; if (sb_if.mem_wdata !== 32'hA000_0000) begin failed++; $display("FAIL head_wdata: got %h exp a0000000", sb_if.mem_wdata); end
        sb_if.st_valid  = 1'b0;
        sb_if.mem_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            tests++; if (sb_if.mem_addr !== exp_addr[i]) begin failed++; $display("FAIL drain_addr_%0d: got %h exp %h", i, sb_if.mem_addr, exp_addr[i]); end
            tests++; if (sb_count !== 3'(4 - i)) begin failed++; $display("FAIL drain_count_%0d: got %0d exp %0d", i, sb_count, 4 - i); end
            tests++; if (sb_if.st_ready !== 1'b1) begin failed++; $display("FAIL drain_ready_%0d: got %0h exp 1", i, sb_if.st_ready); end
        end
        step();
        tests++; if (sb_empty !== 1'b1) begin failed++; $display("FAIL drain_empty: got %0h exp 1", sb_empty); end
        tests++; if (sb_if.mem_valid !== 1'b0) begin failed++; $display("FAIL drain_mem_valid: got %0h exp 0", sb_if.mem_valid); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        sb_if.mem_ready = 1'b1;
        store(32'h40, 2'd2, 32'h0000_0040);
        step();
        tests++; if (sb_if.mem_addr !== 32'h40) begin failed++; $display("FAIL b2b_first_addr: got %h exp 00000040", sb_if.mem_addr); end
        store(32'h44, 2'd2, 32'h0000_0044);
        step();
        tests++; if (sb_count !== 3'd1) begin failed++; $display("FAIL b2b_count: got %0d exp 1", sb_count); end
        tests++; if (sb_if.mem_addr !== 32'h44) begin failed++; $display("FAIL b2b_addr: got %h exp 00000044", sb_if.mem_addr); end
        tests++; if (sb_if.mem_wdata !== 32'h0000_0044) begin failed++; $display("FAIL b2b_wdata: got %h exp 00000044", sb_if.mem_wdata); end
        sb_if.st_valid = 1'b0;
        step();
        tests++; if (sb_empty !== 1'b1) begin failed++; $display("FAIL b2b_empty: got %0h exp 1", sb_empty); end
    endtask

    task automatic test_merge();
        apply_reset();
        sb_if.mem_ready = 1'b0;
        store(32'h3000, 2'd0, 32'h0000_0011);
        step();
        store(32'h3002, 2'd0, 32'h0000_0022);
        step();
        sb_if.st_valid = 1'b0;
`ifdef STORE_BUFFER_MERGE_EN
        tests++; if (sb_count !== 3'd1) begin failed++; $display("FAIL merge_count: got %0d exp 1", sb_count); end
        tests++; if (sb_if.mem_wdata !== 32'h0022_0011) begin failed++; $display("FAIL merge_wdata: got %h exp 00220011", sb_if.mem_wdata); end
        tests++; if (sb_if.mem_be !== 4'b0101) begin failed++; $display("FAIL merge_be: got %b exp 0101", sb_if.mem_be); end
`else
        tests++; if (sb_count !== 3'd2) begin failed++; $display("FAIL nomerge_count: got %0d exp 2", sb_count); end
        tests++; if (sb_if.mem_wdata !== 32'h0000_0011) begin failed++; $display("FAIL nomerge_wdata: got %h exp 00000011", sb_if.mem_wdata); end
        tests++; if (sb_if.mem_be !== 4'b0001) begin failed++; $display("FAIL nomerge_be: got %b exp 0001", sb_if.mem_be); end
`endif
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        sb_if.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            store(32'h50 + 32'(4 * i), 2'd2, 32'h5555_0000 + 32'(i));
            step();
        end
        sb_if.st_valid = 1'b0;
        tests++; if (sb_count !== 3'd3) begin failed++; $display("FAIL mid_pre_count: got %0d exp 3", sb_count); end
        sb_if.mem_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++; if (sb_count !== 3'd0) begin failed++; $display("FAIL mid_count: got %0d exp 0", sb_count); end
        tests++; if (sb_if.mem_valid !== 1'b0) begin failed++; $display("FAIL mid_mem_valid: got %0h exp 0", sb_if.mem_valid); end
        tests++; if (sb_empty !== 1'b1) begin failed++; $display("FAIL mid_empty: got %0h exp 1", sb_empty); end
        tests++; if (sb_if.mem_be !== 4'h0) begin failed++; $display("FAIL mid_mem_be: got %b exp 0000", sb_if.mem_be); end
    endtask

    initial begin
        sb_if.st_valid    = 1'b0;
        sb_if.st_addr     = '0;
        sb_if.st_size     = '0;
        sb_if.st_data     = '0;
        sb_if.mem_ready   = 1'b0;
        sb64_if.st_valid  = 1'b0;
        sb64_if.st_addr   = '0;
        sb64_if.st_size   = '0;
        sb64_if.st_data   = '0;
        sb64_if.mem_ready = 1'b0;
        #2;
        test_reset();
        test_byte_store();
        test_misaligned();
        test_oversize();
        test_fill_drain();
        test_back_to_back();
        test_merge();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Parametrised store path between the execute stage and data memory. Accepts byte/half/word/doubleword stores, aligns the data onto byte lanes with zero fill and byte enables, and rejects misaligned or oversize stores with a one-cycle error pulse. Accepted stores are queued in a DEPTH-entry FIFO and drained in program order over a valid/ready memory-write handshake. Optionally, a new store is merged into the newest queued entry when both target the same memory word.

## Interface
- DATA_W, 32, memory word width; 32 or 64. BYTES = DATA_W/8.
- ADDR_W, 32, byte-address width.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- st_valid  in  1  store request present.
- st_ready  out  1  buffer can accept a store.
- st_addr  in  ADDR_W  store byte address.
- st_size  in  2  log2 of the store size in bytes: 0 byte, 1 half, 2 word, 3 doubleword.
- st_data  in  DATA_W  store data, right-justified in the low bits.
- st_err  out  1  misaligned or oversize store was rejected.
- mem_valid  out  1  head entry is presented to memory.
- mem_ready  in  1  memory accepts the head entry.
- mem_addr  out  ADDR_W  word-aligned address; low log2(BYTES) bits are 0.
- mem_wdata  out  DATA_W  lane-aligned write data.
- mem_be  out  BYTES  byte enables.
- sb_empty  out  1  FIFO holds no entries.
- sb_count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Alignment:
  - off = st_addr[log2(BYTES)-1:0]; nbytes = 1<<st_size.
  - be = ((1<<nbytes)-1) << off.
  - data = (st_data masked to nbytes) << (8*off); lanes outside be are 0.
  - Word address = st_addr with its low log2(BYTES) bits cleared.
- Illegal store: nbytes > BYTES, or off not a multiple of nbytes.
  - The store is not enqueued and no state changes.
  - st_err is asserted for exactly one cycle, in the cycle after the request.
  - An illegal store is rejected whenever st_valid=1, regardless of st_ready.
- Accept: st_valid && st_ready && legal.
- st_ready = !full. It depends only on registered state, never on st_valid.
- Drain:
  - mem_valid = !empty.
  - mem_addr, mem_wdata and mem_be come from the head entry's registers.
  - The entry is popped on mem_valid && mem_ready.
  - The head must stay stable while mem_valid=1 and mem_ready=0.
- Push and pop in the same cycle are allowed at any occupancy below full, and sb_count is unchanged. When the FIFO is full a push is impossible (st_ready=0), even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH.
- Order is strict FIFO; no reordering.

## Timing
- Reset values:
  - st_ready=1, st_err=0, mem_valid=0.
  - mem_addr=0, mem_wdata=0, mem_be=0 (all storage cleared).
  - sb_empty=1, sb_count=0, pointers 0.
- Reset mid-operation discards all pending stores. Outputs take their reset values in the cycle after reset is sampled.
- Latency:
  - A store accepted at edge N is visible on mem_* after edge N, i.e. in the cycle following acceptance, when the FIFO was empty.
  - There is no combinational path from st_* to mem_*.
- Throughput is one store in and one store out per cycle.
- st_ready deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop from full.

## Configuration
- Macro: STORE_BUFFER_MERGE_EN.
- With the macro defined, an accepted legal store is merged into the tail entry instead of being pushed when:
  - its word address equals the tail entry's address, and
  - either sb_count >= 2, or sb_count == 1 and no pop occurs in that cycle.
- Merge behaviour:
  - Tail lanes selected by the new be are overwritten.
  - Tail be |= new be.
  - sb_count is unchanged.
  - st_ready is still !full, so a merge can never occur while the FIFO is full.
- Without the macro, every accepted store occupies its own entry.

## Test plan
- Byte store, DATA_W=32: reset, then a byte store to 0x1003 with data 0x000000AB, mem_ready=0. Next cycle: mem_valid=1, mem_addr=0x1000, mem_wdata=0xAB000000, mem_be=4'b1000, sb_count=1.
- Misaligned half: half store to 0x2001. Next cycle st_err=1 for exactly one cycle; sb_count=0 and mem_valid=0 throughout.
- Oversize store: st_size=3 with DATA_W=32 -> st_err pulse and nothing enqueued. With DATA_W=64, a doubleword to 0x08 -> mem_be=8'hFF.
- Fill and drain: mem_ready=0, four word stores to 0x10/0x14/0x18/0x1C -> sb_count=4 and st_ready=0; a fifth store is held. Raise mem_ready -> addresses 0x10, 0x14, 0x18, 0x1C drain one per cycle; st_ready=1 one cycle after the first pop.
- Merge: mem_ready=0, byte 0x11 to 0x3000, then byte 0x22 to 0x3002.
  - With STORE_BUFFER_MERGE_EN: sb_count=1, mem_wdata=0x00220011, mem_be=4'b0101.
  - Without it: sb_count=2.
- Reset mid-drain: with sb_count=3 and mem_ready=1, assert reset for one cycle. Next cycle: sb_count=0, mem_valid=0, sb_empty=1, mem_be=0.
